twos_comp_engine: RTL and testbench

Parametrised, multi-cycle two's-complement unit that generalises the combinational negator. It supports selectable modes (pass, negate, absolute value) and processes the operand CHUNK_W bits per cycle through a ripple-carry chunk adder. Operands and results move over valid/ready handshakes, and the unit produces ARM-style N/Z/V flags. It sits beside the ALU for multi-cycle NEG/ABS micro-ops and trades latency for area versus the full-width ripple negator.

---
 rtl/twos_comp_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/tc_chunk_adder.sv | 31 +++
 rtl/twos_comp_engine.sv | 124 ++++++++++++
 tb/tb_twos_comp_engine.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/twos_comp_pkg.sv
// Shared types for the multi-cycle two's-complement engine.
package twos_comp_pkg;

  typedef enum logic [1:0] {
    TC_PASS,
    TC_NEG,
    TC_ABS,
    TC_RSVD
  } tc_mode_t;

  typedef enum logic [1:0] {
    TC_IDLE,
    TC_BUSY,
    TC_DONE
  } tc_state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/tc_chunk_adder.sv
// Chunk adder: (inv ? ~a : a) + cin as a ripple chain of full_adder cells.
module tc_chunk_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic         inv,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0]   c;
  logic [W-1:0] b;

  assign c[0] = cin;
  assign b    = inv ? ~a : a;

  // Only the incoming carry is added, so the second adder input is tied low.
  for (genvar i = 0; i < W; i++) begin : g_fa
    full_adder u_fa (
      .a   (b[i]),
      .b   (1'b0),
      .cin (c[i]),
      .sum (sum[i]),
      .cout(c[i+1])
    );
  end

  assign cout = c[W];

endmodule

// File: rtl/twos_comp_engine.sv
// Multi-cycle pass/negate/abs unit processing CHUNK_W bits per cycle,
// with valid/ready handshakes and N/Z/V result flags.
module twos_comp_engine
  import twos_comp_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int CHUNK_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_n,
  output logic             out_z,
  output logic             out_v
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK_W;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  if (WIDTH % CHUNK_W != 0) begin : g_chunk_check
    $error("twos_comp_engine: WIDTH must be a multiple of CHUNK_W");
  end

  tc_state_t          state;
  tc_mode_t           mode;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               inv;
  logic               inv_new;
  logic               z_acc;
  logic               accept;
  logic               last;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   result;
  logic [WIDTH-1:0]   res_next;
  logic [CHUNK_W-1:0] chunk;
  logic [CHUNK_W-1:0] sum;
  logic               cout;

  assign in_ready  = (state == TC_IDLE) || ((state == TC_DONE) && out_ready);
  assign out_valid = (state == TC_DONE);
  assign accept    = in_valid && in_ready;
  assign mode      = tc_mode_t'(in_mode);
  // Reserved mode behaves as PASS because it never requests inversion.
  assign inv_new   = (mode == TC_NEG) || ((mode == TC_ABS) && in_data[WIDTH-1]);
  assign last      = (cnt == LAST_CNT);
  assign chunk     = operand[cnt*CHUNK_W +: CHUNK_W];

  tc_chunk_adder #(.W(CHUNK_W)) u_adder (
    .a   (chunk),
    .inv (inv),
    .cin (carry),
    .sum (sum),
    .cout(cout)
  );

  // Merge the current chunk sum into the working result.
  always_comb begin
    res_next = result;
    res_next[cnt*CHUNK_W +: CHUNK_W] = sum;
  end

  // Operand capture at acceptance and per-chunk result accumulation.
  always_ff @(posedge clk) begin
    if (accept) begin
      operand <= in_data;
    end
    if (state == TC_BUSY) begin
      result <= res_next;
    end
  end

  // Control FSM, chunk counter, carry chain state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= TC_IDLE;
      cnt      <= '0;
      carry    <= 1'b0;
      inv      <= 1'b0;
      z_acc    <= 1'b0;
      out_data <= '0;
      out_n    <= 1'b0;
      out_z    <= 1'b0;
      out_v    <= 1'b0;
    end else begin
      case (state)
        TC_BUSY: begin
          carry <= cout;
          z_acc <= z_acc && (sum == '0);
          cnt   <= cnt + 1'b1;
          if (last) begin
            state    <= TC_DONE;
            out_data <= res_next;
            out_n    <= res_next[WIDTH-1];
            out_z    <= z_acc && (sum == '0);
            out_v    <= inv && res_next[WIDTH-1] && (operand == res_next);
          end
        end
        TC_DONE: begin
          if (out_ready && !in_valid) begin
            state <= TC_IDLE;
          end
        end
        default: ;
      endcase
      // Acceptance from IDLE or directly out of DONE (no IDLE bubble).
      if (accept) begin
        state <= TC_BUSY;
        inv   <= inv_new;
        carry <= inv_new;
        cnt   <= '0;
        z_acc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_twos_comp_engine.sv
// Self-checking bench for twos_comp_engine: three configurations
// (64/16, 64/64, 8/1) checked against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_twos_comp_engine;

  typedef struct packed {
    logic [1:0]  m;
    logic [63:0] d;
    logic [63:0] e;
    logic        n;
    logic        z;
    logic        v;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] in_data = '0;
  logic [1:0]  in_mode = '0;

  logic        iv  [3];
  logic        orr [3];
  logic        ir  [3];
  logic        ov  [3];
  logic [63:0] od  [3];
  logic        on_ [3];
  logic        oz  [3];
  logic        ovf [3];
  logic [7:0]  od8;
  logic [63:0] od0, od1;

  int compared   = 0;
  int mismatched = 0;
  int nc [3] = '{4, 1, 8};
  int wd [3] = '{64, 64, 8};

  always #5 clk = ~clk;

  twos_comp_engine #(.WIDTH(64), .CHUNK_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov[0]), .out_ready(orr[0]),
    .out_data(od0), .out_n(on_[0]), .out_z(oz[0]), .out_v(ovf[0])
  );

  twos_comp_engine #(.WIDTH(64), .CHUNK_W(64)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(in_data), .in_mode(in_mode), .out_valid(ov[1]), .out_ready(orr[1]),
    .out_data(od1), .out_n(on_[1]), .out_z(oz[1]), .out_v(ovf[1])
  );

  twos_comp_engine #(.WIDTH(8), .CHUNK_W(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(in_data[7:0]), .in_mode(in_mode), .out_valid(ov[2]), .out_ready(orr[2]),
    .out_data(od8), .out_n(on_[2]), .out_z(oz[2]), .out_v(ovf[2])
  );

  assign od[0] = od0;
  assign od[1] = od1;
  assign od[2] = {56'd0, od8};

  // Reference: result = operand, its arithmetic negation, or its magnitude,
  // truncated to w bits; returns {n, z, v, result}.
  function automatic logic [66:0] model(input logic [1:0] mode, input logic [63:0] d, input int w);
    logic [63:0] mask, msb, dm, r;
    logic        neg, inv;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    msb  = 64'd1 << (w - 1);
    dm   = d & mask;
    neg  = (dm & msb) != 0;
    inv  = (mode == 2'd1) || (mode == 2'd2 && neg);
    r    = inv ? ((64'd0 - dm) & mask) : dm;
    return {(r & msb) != 0, r == 0, inv && (dm == msb), r};
  endfunction

  // Drive one operand into DUT sel, measure edges to out_valid, capture and retire.
  task automatic do_op(input int sel, input logic [1:0] mode, input logic [63:0] d,
                       output int lat, output logic [63:0] r, output logic n, z, v);
    int guard;
    @(negedge clk);
    in_mode = mode; in_data = d; iv[sel] = 1'b1;
    guard = 0;
    while (!ir[sel] && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    iv[sel] = 1'b0;
    in_mode = 2'($urandom);
    in_data = {$urandom, $urandom};
    lat = 0;
    while (!ov[sel] && lat < 40) begin @(posedge clk); #1; lat++; end
    r = od[sel]; n = on_[sel]; z = oz[sel]; v = ovf[sel];
    @(negedge clk); orr[sel] = 1'b1;
    @(posedge clk); #1; orr[sel] = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    compared++;
    if (ov[0] !== 1'b0 || od[0] !== 64'd0 || on_[0] !== 1'b0 || oz[0] !== 1'b0 || ovf[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got valid=%b data=%h nzv=%b%b%b required all zero",
               ov[0], od[0], on_[0], oz[0], ovf[0]);
    end
    compared++;
    if (ir[0] !== 1'b1 || ir[1] !== 1'b1 || ir[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b%b%b required 111", ir[0], ir[1], ir[2]);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors64(input int sel);
    vec_t tv [9];
    int lat; logic [63:0] r; logic n, z, v;
    tv = '{
      '{2'd1, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0},
      '{2'd1, 64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0, 1'b1, 1'b0},
      '{2'd1, 64'h0000_0000_0001_0000, 64'hFFFF_FFFF_FFFF_0000, 1'b1, 1'b0, 1'b0},
      '{2'd2, 64'hFFFF_FFFF_FFFF_FFFB, 64'h0000_0000_0000_0005, 1'b0, 1'b0, 1'b0},
      '{2'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1},
      '{2'd2, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0007, 1'b0, 1'b0, 1'b0},
      '{2'd0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0},
      '{2'd3, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0},
      '{2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0}
    };
    foreach (tv[i]) begin
      do_op(sel, tv[i].m, tv[i].d, lat, r, n, z, v);
      compared++;
      if (lat !== nc[sel]) begin
        mismatched++;
        $display("FAIL vec64_latency cfg%0d #%0d: got %0d required %0d", sel, i, lat, nc[sel]);
      end
      compared++;
      if (r !== tv[i].e || {n, z, v} !== {tv[i].n, tv[i].z, tv[i].v}) begin
        mismatched++;
        $display("FAIL vec64_result cfg%0d #%0d: got %h nzv=%b%b%b required %h nzv=%b%b%b",
                 sel, i, r, n, z, v, tv[i].e, tv[i].n, tv[i].z, tv[i].v);
      end
    end
  endtask

  task automatic test_vectors8();
    vec_t tv [7];
    int lat; logic [63:0] r; logic n, z, v;
    tv = '{
      '{2'd1, 64'h01, 64'hFF, 1'b1, 1'b0, 1'b0},
      '{2'd1, 64'h00, 64'h00, 1'b0, 1'b1, 1'b0},
      '{2'd2, 64'hFB, 64'h05, 1'b0, 1'b0, 1'b0},
      '{2'd2, 64'h80, 64'h80, 1'b1, 1'b0, 1'b1},
      '{2'd2, 64'h07, 64'h07, 1'b0, 1'b0, 1'b0},
      '{2'd1, 64'h80, 64'h80, 1'b1, 1'b0, 1'b1},
      '{2'd0, 64'h80, 64'h80, 1'b1, 1'b0, 1'b0}
    };
    foreach (tv[i]) begin
      do_op(2, tv[i].m, tv[i].d, lat, r, n, z, v);
      compared++;
      if (lat !== 8) begin
        mismatched++;
        $display("FAIL vec8_latency #%0d: got %0d required 8", i, lat);
      end
      compared++;
      if (r !== tv[i].e || {n, z, v} !== {tv[i].n, tv[i].z, tv[i].v}) begin
        mismatched++;
        $display("FAIL vec8_result #%0d: got %h nzv=%b%b%b required %h nzv=%b%b%b",
                 i, r, n, z, v, tv[i].e, tv[i].n, tv[i].z, tv[i].v);
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [63:0] r, d; logic n, z, v; logic [1:0] m; logic [66:0] e;
    for (int sel = 0; sel < 3; sel++) begin
      for (int k = 0; k < 25; k++) begin
        m = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 7))
          0: d = 64'd0;
          1: d = 64'd1 << (wd[sel] - 1);
          2: d = '1;
          default: d = {$urandom, $urandom};
        endcase
        e = model(m, d, wd[sel]);
        do_op(sel, m, d, lat, r, n, z, v);
        compared++;
        if (lat !== nc[sel] || r !== e[63:0] || {n, z, v} !== e[66:64]) begin
          mismatched++;
          $display("FAIL random cfg%0d mode=%0d op=%h: got %h nzv=%b%b%b lat=%0d required %h nzv=%b%b%b lat=%0d",
                   sel, m, d, r, n, z, v, lat, e[63:0], e[66], e[65], e[64], nc[sel]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [66:0] e;
    e = model(2'd1, 64'h5, 64);
    @(negedge clk); in_mode = 2'd1; in_data = 64'h5; iv[0] = 1'b1;
    @(posedge clk); #1; iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    compared++;
    if (lat !== 4) begin
      mismatched++;
      $display("FAIL stall_latency: got %0d required 4", lat);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); iv[0] = 1'b1; in_mode = 2'($urandom); in_data = {$urandom, $urandom};
      @(posedge clk); #1;
      compared++;
      if (ov[0] !== 1'b1 || ir[0] !== 1'b0 || od[0] !== e[63:0] || {on_[0], oz[0], ovf[0]} !== e[66:64]) begin
        mismatched++;
        $display("FAIL stall_hold cyc%0d: got valid=%b ready=%b data=%h nzv=%b%b%b required 1 0 %h %b",
                 k, ov[0], ir[0], od[0], on_[0], oz[0], ovf[0], e[63:0], e[66:64]);
      end
    end
    // Retire and accept on the same edge.
    e = model(2'd2, 64'hFFFF_FFFF_FFFF_FFF0, 64);
    @(negedge clk); orr[0] = 1'b1; iv[0] = 1'b1; in_mode = 2'd2; in_data = 64'hFFFF_FFFF_FFFF_FFF0;
    @(posedge clk); #1; orr[0] = 1'b0; iv[0] = 1'b0;
    compared++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_accept: got valid=%b ready=%b required 0 0", ov[0], ir[0]);
    end
    lat = 0;
    while (!ov[0] && lat < 40) begin @(posedge clk); #1; lat++; end
    compared++;
    if (lat !== 4 || od[0] !== e[63:0] || {on_[0], oz[0], ovf[0]} !== e[66:64]) begin
      mismatched++;
      $display("FAIL b2b_result: got %h nzv=%b%b%b lat=%0d required %h nzv=%b lat=4",
               od[0], on_[0], oz[0], ovf[0], lat, e[63:0], e[66:64]);
    end
    // Retire with no new operand: back to IDLE, data held.
    @(negedge clk); orr[0] = 1'b1;
    @(posedge clk); #1; orr[0] = 1'b0;
    compared++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== e[63:0]) begin
      mismatched++;
      $display("FAIL retire_idle: got valid=%b ready=%b data=%h required 0 1 %h",
               ov[0], ir[0], od[0], e[63:0]);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat; logic [63:0] r; logic n, z, v; int seen;
    @(negedge clk); in_mode = 2'd1; in_data = {$urandom, $urandom}; iv[0] = 1'b1;
    @(posedge clk); #1; iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    compared++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || od[0] !== 64'd0) begin
      mismatched++;
      $display("FAIL reset_busy: got valid=%b ready=%b data=%h required 0 1 0", ov[0], ir[0], od[0]);
    end
    @(negedge clk); reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ov[0] !== 1'b0) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL reset_no_partial: got %0d valid cycles required 0", seen);
    end
    do_op(0, 2'd1, 64'h2, lat, r, n, z, v);
    compared++;
    if (lat !== 4 || r !== 64'hFFFF_FFFF_FFFF_FFFE || {n, z, v} !== 3'b100) begin
      mismatched++;
      $display("FAIL post_reset_neg: got %h nzv=%b%b%b lat=%0d required fffffffffffffffe nzv=100 lat=4",
               r, n, z, v, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin iv[i] = 1'b0; orr[i] = 1'b0; end
    test_reset();
    test_vectors64(0);
    test_vectors64(1);
    test_vectors8();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
